lu_serial_sequencer: RTL and testbench
======================================

Name: lu_serial_sequencer

Overview:
Bit-serial operand sequencer and result collector for the 1-bit OR/NOR logic unit. It accepts two WIDTH-bit words plus an operation select. It then presents one bit pair per clock, LSB first, to the external 1-bit unit, and shifts the returned bit into a result word. The block sits on both sides of the 1-bit unit: it drives the unit's a/b/sel inputs and consumes its combinational output. A done pulse signals that the full WIDTH-bit result is valid.

Parameters:
WIDTH, 4, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A; captured on accepted start
b  input  WIDTH  operand B; captured on accepted start
op  input  1  0 = NOR, 1 = OR; captured on accepted start
busy  output  1  high in SHIFT and DONE
done  output  1  one-cycle pulse; result valid
result  output  WIDTH  assembled result; held until the next accepted start
lu_a  output  1  bit to the 1-bit unit's a input
lu_b  output  1  bit to the 1-bit unit's b input
lu_sel  output  1  select to the 1-bit unit (0 NOR, 1 OR)
lu_out  input  1  combinational output of the 1-bit unit

Behaviour:
- Reset (rst=1 at a clk edge): state goes to IDLE. busy=0, done=0, result=0, lu_a=0, lu_b=0, lu_sel=0, bit counter=0, shift registers=0.
- rst has priority over every other input in any state, including mid-SHIFT. An aborted operation produces no done, and result is cleared.
- State machine:
  - IDLE -> SHIFT on start=1. At that edge: a_sh<=a, b_sh<=b, op_r<=op, cnt<=0, res_sh<=0.
  - SHIFT -> SHIFT while cnt < WIDTH-1.
  - SHIFT -> DONE on the edge where cnt == WIDTH-1.
  - DONE -> IDLE unconditionally after one cycle.
- lu_a=a_sh[0], lu_b=b_sh[0], lu_sel=op_r. All three are driven straight from registers, giving a glitch-free, stable bit pair for the whole cycle. In IDLE they hold their last values; after reset they are 0.
- Each SHIFT edge:
  - res_sh <= {lu_out, res_sh[WIDTH-1:1]} (LSB-first collection).
  - a_sh and b_sh shift right by 1, filling with 0.
  - cnt increments.
- On the SHIFT->DONE edge, result <= {lu_out, res_sh[WIDTH-1:1]}. result is updated only on that edge and by reset.
- done=1 exactly during the DONE cycle. busy=1 in SHIFT and DONE.
- Latency: start sampled at edge 0 gives SHIFT for WIDTH cycles and done high in the cycle after edge WIDTH. Total WIDTH+1 cycles, start to done.
- start while busy (SHIFT or DONE) is ignored and is not queued.
- a, b and op changing after acceptance have no effect.
- Back-to-back: start held high continuously is re-accepted in the IDLE cycle following DONE. Minimum period is WIDTH+2 cycles.
- Counter width: $clog2(WIDTH). It must not wrap before WIDTH-1 is reached. Out-of-range cnt values are unreachable; if one is ever reached, go to IDLE.
- Unused state encoding: go to IDLE.

Decomposition:
- Shared package lu_pkg holds:
  - OP_NOR=1'b0 and OP_OR=1'b1;
  - the state type with IDLE=2'd0, SHIFT=2'd1, DONE=2'd2;
  - the width-range check constants.
- One natural sub-module, lu_bit_counter: a parameterised up-counter with synchronous clear, enable, and terminal-count flag (cnt == WIDTH-1). The FSM, shift registers and result register stay in lu_serial_sequencer.
- The bench connects the real 1-bit OR/NOR unit between lu_a/lu_b/lu_sel and lu_out.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then start=0 for 5 cycles -> busy=0, done=0, result=4'b0000, lu_a=lu_b=lu_sel=0 throughout.
- OR, WIDTH=4: a=4'b0101, b=4'b0011, op=1, start pulse -> lu_a sequence 1,0,1,0; lu_b sequence 1,1,0,0; done exactly 5 cycles after the start edge; result=4'b0111, held after done.
- NOR, WIDTH=4: a=4'b0101, b=4'b0011, op=0 -> result=4'b1000. Then a=0, b=0, op=0 -> result=4'b1111.
- Ignored start: during SHIFT, pulse start with a=4'b1111, op=0 -> no effect; result=4'b0111 from the original OR request; only one done pulse.
- Reset mid-operation: rst=1 at the 2nd SHIFT cycle -> IDLE next cycle, no done, result=0. A fresh start afterwards completes normally in WIDTH+1 cycles.
- Back-to-back and width: start held high for 12 cycles, WIDTH=4 -> done pulses 6 cycles apart. Repeat with WIDTH=8, a=8'hA5, b=8'h0F, op=1 -> result=8'hAF, done 9 cycles after start.

Source files
------------

// File: rtl/lu_pkg.sv
// Shared definitions for the bit-serial OR/NOR sequencer: op codes,
// FSM state type and the legal operand-width range.
package lu_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  localparam logic OP_NOR = 1'b0;
  localparam logic OP_OR  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic bit width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/lu_bit_counter.sv
// Bit-position counter for the serial sequencer: synchronous clear, enable,
// terminal-count flag at WIDTH-1 and a flag for unreachable values.
module lu_bit_counter
  import lu_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc,
  output logic             over
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_r;

  // counter register; clear wins over enable
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt  = cnt_r;
  assign tc   = (cnt_r == CNT_LAST);
  // only possible for non-power-of-two widths, and only after an upset
  assign over = (int'(cnt_r) > (WIDTH - 1));

endmodule

// File: rtl/lu_serial_sequencer.sv
// Feeds two WIDTH-bit operands LSB-first to an external 1-bit OR/NOR unit and
// reassembles its serial output into a result word, pulsing done when complete.
module lu_serial_sequencer
  import lu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             lu_a,
  output logic             lu_b,
  output logic             lu_sel,
  input  logic             lu_out
);

  localparam int CNT_W = $clog2(WIDTH);

  if (!width_ok(WIDTH)) begin : g_width_check
    $error("lu_serial_sequencer: WIDTH out of range");
  end

  state_e           state_r, next_state_s;
  logic [WIDTH-1:0] a_sh_r, b_sh_r, res_sh_r, result_r;
  logic             op_r, busy_r, done_r;
  logic             load_s, shift_s, cnt_tc_s, cnt_over_s;
  logic [CNT_W-1:0] cnt_s;

  lu_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (load_s),
    .en   (shift_s),
    .cnt  (cnt_s),
    .tc   (cnt_tc_s),
    .over (cnt_over_s)
  );

  // next-state and datapath strobes
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    shift_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = SHIFT;
          load_s       = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_over_s) begin
          next_state_s = IDLE;
        end else if (cnt_tc_s) begin
          next_state_s = DONE;
          shift_s      = 1'b1;
        end else begin
          next_state_s = SHIFT;
          shift_s      = 1'b1;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // state register and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == SHIFT) || (next_state_s == DONE);
      done_r  <= (next_state_s == DONE);
    end
  end

  // operand capture, serial shifting and result collection
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      res_sh_r <= {WIDTH{1'b0}};
      result_r <= {WIDTH{1'b0}};
      op_r     <= 1'b0;
    end else if (load_s) begin
      a_sh_r   <= a;
      b_sh_r   <= b;
      op_r     <= op;
      res_sh_r <= {WIDTH{1'b0}};
    end else if (shift_s) begin
      a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
      b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
      res_sh_r <= {lu_out, res_sh_r[WIDTH-1:1]};
      if (cnt_tc_s) begin
        result_r <= {lu_out, res_sh_r[WIDTH-1:1]};
      end
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign lu_a   = a_sh_r[0];
  assign lu_b   = b_sh_r[0];
  assign lu_sel = op_r;

endmodule

// File: tb/tb_lu_serial_sequencer.sv
// Randomised self-checking bench for lu_serial_sequencer at WIDTH=4 and WIDTH=8,
// each DUT closed around a behavioural 1-bit OR/NOR unit.
module tb_lu_serial_sequencer;
  import lu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start4, op4, start8, op8;
  logic [3:0] a4, b4;
  logic [7:0] a8, b8;
  logic       busy4, done4, lu_a4, lu_b4, lu_sel4, lu_out4;
  logic       busy8, done8, lu_a8, lu_b8, lu_sel8, lu_out8;
  logic [3:0] result4;
  logic [7:0] result8;

  assign lu_out4 = lu_sel4 ? (lu_a4 | lu_b4) : ~(lu_a4 | lu_b4);
  assign lu_out8 = lu_sel8 ? (lu_a8 | lu_b8) : ~(lu_a8 | lu_b8);

  lu_serial_sequencer #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .op(op4),
    .busy(busy4), .done(done4), .result(result4),
    .lu_a(lu_a4), .lu_b(lu_b4), .lu_sel(lu_sel4), .lu_out(lu_out4)
  );

  lu_serial_sequencer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .op(op8),
    .busy(busy8), .done(done8), .result(result8),
    .lu_a(lu_a8), .lu_b(lu_b8), .lu_sel(lu_sel8), .lu_out(lu_out8)
  );

  int tests = 0;
  int fails = 0;
  logic        obs_busy, obs_done, obs_la, obs_lb, obs_ls;
  logic [31:0] obs_res;

  task automatic sample(input int w);
    if (w == 8) begin
      obs_busy = busy8; obs_done = done8; obs_la = lu_a8; obs_lb = lu_b8;
      obs_ls = lu_sel8; obs_res = {24'd0, result8};
    end else begin
      obs_busy = busy4; obs_done = done4; obs_la = lu_a4; obs_lb = lu_b4;
      obs_ls = lu_sel4; obs_res = {28'd0, result4};
    end
  endtask

  task automatic set_in(input int w, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic op);
    if (w == 8) begin
      start8 = s; a8 = a[7:0]; b8 = b[7:0]; op8 = op;
    end else begin
      start4 = s; a4 = a[3:0]; b4 = b[3:0]; op4 = op;
    end
  endtask

  // word-level model: the unit ORs or NORs each bit pair, so the whole result is one word op
  function automatic logic [31:0] ref_result(input int w, input logic [31:0] a,
                                             input logic [31:0] b, input logic op);
    logic [31:0] m;
    m = (32'h1 << w) - 32'h1;
    return ((op == OP_OR) ? (a | b) : ~(a | b)) & m;
  endfunction

  // one start pulse, checking every cycle up to one past done
  task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic op,
                        input string tag);
    logic [31:0] exp_res;
    logic [4:0]  exp_v, got_v;
    exp_res = ref_result(w, a, b, op);
    set_in(w, 1'b1, a, b, op);
    for (int k = 1; k <= w + 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) set_in(w, 1'b0, $urandom, $urandom, 1'($urandom));
      sample(w);
      if (k <= w)          exp_v = {1'b1, 1'b0, a[k-1], b[k-1], op};
      else if (k == w + 1) exp_v = {1'b1, 1'b1, 1'b0, 1'b0, op};
      else                 exp_v = {1'b0, 1'b0, 1'b0, 1'b0, op};
      got_v = {obs_busy, obs_done, obs_la, obs_lb, obs_ls};
      tests++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL %s w%0d cycle %0d busy/done/lu_a/lu_b/lu_sel: got %b expected %b",
                 tag, w, k, got_v, exp_v);
      end
      if (k >= w + 1) begin
        tests++;
        if (obs_res !== exp_res) begin
          fails++;
          $display("FAIL %s w%0d result cycle %0d: got %h expected %h", tag, w, k, obs_res, exp_res);
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [36:0] got;
    rst = 1'b1;
    set_in(4, 1'b0, 32'd0, 32'd0, 1'b0);
    set_in(8, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      for (int w = 4; w <= 8; w += 4) begin
        sample(w);
        got = {obs_busy, obs_done, obs_la, obs_lb, obs_ls, obs_res};
        tests++;
        if (got !== 37'd0) begin
          fails++;
          $display("FAIL reset_idle w%0d cycle %0d: got %h expected 0", w, k, got);
        end
      end
    end
  endtask

  task automatic test_or_nor();
    run_op(4, 32'h5, 32'h3, OP_OR, "or_0101_0011");
    run_op(4, 32'h5, 32'h3, OP_NOR, "nor_0101_0011");
    run_op(4, 32'h0, 32'h0, OP_NOR, "nor_zero");
  endtask

  task automatic test_ignored_start();
    int          ndone;
    logic [31:0] res_at_done;
    ndone = 0;
    res_at_done = 32'd0;
    set_in(4, 1'b1, 32'h5, 32'h3, OP_OR);
    @(posedge clk); @(negedge clk);
    set_in(4, 1'b0, 32'h5, 32'h3, OP_OR);
    @(posedge clk); @(negedge clk);
    set_in(4, 1'b1, 32'hF, 32'h0, OP_NOR);
    @(posedge clk); @(negedge clk);
    set_in(4, 1'b0, 32'hF, 32'h0, OP_NOR);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); @(negedge clk);
      sample(4);
      if (obs_done === 1'b1) begin
        ndone++;
        res_at_done = obs_res;
      end
    end
    tests++;
    if (ndone != 1) begin
      fails++;
      $display("FAIL ignored_start done count: got %0d expected 1", ndone);
    end
    tests++;
    if (res_at_done !== ref_result(4, 32'h5, 32'h3, OP_OR)) begin
      fails++;
      $display("FAIL ignored_start result: got %h expected %h", res_at_done,
               ref_result(4, 32'h5, 32'h3, OP_OR));
    end
  endtask

  task automatic test_reset_mid();
    logic [36:0] got;
    int          ndone;
    ndone = 0;
    set_in(4, 1'b1, 32'h5, 32'h3, OP_NOR);
    @(posedge clk); @(negedge clk);
    set_in(4, 1'b0, 32'h5, 32'h3, OP_NOR);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    sample(4);
    got = {obs_busy, obs_done, obs_la, obs_lb, obs_ls, obs_res};
    tests++;
    if (got !== 37'd0) begin
      fails++;
      $display("FAIL reset_mid state: got %h expected 0", got);
    end
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); @(negedge clk);
      if (done4 === 1'b1) ndone++;
    end
    tests++;
    if (ndone != 0) begin
      fails++;
      $display("FAIL reset_mid spurious done: got %0d expected 0", ndone);
    end
    run_op(4, 32'h9, 32'h4, OP_OR, "after_reset");
  endtask

  task automatic test_back_to_back();
    int first, second, ndone;
    first = -1; second = -1; ndone = 0;
    set_in(4, 1'b1, 32'hA, 32'h1, OP_NOR);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); @(negedge clk);
      if (done4 === 1'b1) begin
        ndone++;
        if (first < 0) first = k; else second = k;
      end
    end
    set_in(4, 1'b0, 32'hA, 32'h1, OP_NOR);
    tests++;
    if (ndone != 2 || first != 5 || second != 11) begin
      fails++;
      $display("FAIL back_to_back done cycles: got n=%0d at %0d,%0d expected n=2 at 5,11",
               ndone, first, second);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    sample(4);
    tests++;
    if ({obs_busy, obs_res} !== {1'b0, ref_result(4, 32'hA, 32'h1, OP_NOR)}) begin
      fails++;
      $display("FAIL back_to_back final busy/result: got %b/%h expected 0/%h", obs_busy, obs_res,
               ref_result(4, 32'hA, 32'h1, OP_NOR));
    end
  endtask

  task automatic test_width8();
    run_op(8, 32'hA5, 32'h0F, OP_OR, "w8_a5_0f");
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      run_op(4, $urandom, $urandom, 1'($urandom), "rand4");
      run_op(8, $urandom, $urandom, 1'($urandom), "rand8");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_or_nor();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    test_width8();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
